// File: rtl/arb_n_pkg.sv
// ---------------------------------------------------------------------------
// arb_n_pkg
// Shared definitions for the N-master memory arbiter:
//   - arb_state_e : arbiter FSM state encoding (ARB_IDLE / ARB_BUSY)
//   - ARB_DEF_AW / ARB_DEF_DW : default address / data widths
//   - arb_cnt_w() : width of the bus-timeout counter, never narrower than 1 bit
// ---------------------------------------------------------------------------
package arb_n_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_DEF_AW = 32;
    localparam int ARB_DEF_DW = 32;

    // Counter width able to hold 0..timeout; a disabled timeout still gets 1 bit.
    function automatic int arb_cnt_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_n_pick.sv
// ---------------------------------------------------------------------------
// arb_n_pick
// Combinational priority encoder choosing one requester.
//   ARB_ROUND_ROBIN_EN defined : rotating priority, search starts at i_last+1
//                                and wraps from NPORTS-1 to 0.
//   ARB_ROUND_ROBIN_EN absent  : fixed priority, lowest index wins; the
//                                i_last port does not exist in this build.
// Ports:
//   i_req    [NPORTS-1:0] request vector
//   i_last   [IW-1:0]     last granted port (round-robin build only)
//   o_onehot [NPORTS-1:0] one-hot winner
//   o_idx    [IW-1:0]     binary winner index
//   o_any                 at least one request present
// ---------------------------------------------------------------------------
module arb_n_pick #(
    parameter int NPORTS = 2,
    parameter int IW     = 1
) (
    input  logic [NPORTS-1:0] i_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0]     i_last,
`endif
    output logic [NPORTS-1:0] o_onehot,
    output logic [IW-1:0]     o_idx,
    output logic              o_any
);

    logic [NPORTS-1:0] w_src;
`ifdef ARB_ROUND_ROBIN_EN
    logic [NPORTS-1:0] w_mask;
    logic [NPORTS-1:0] w_hi;
`endif

    // Select the search vector, then take its lowest set bit.
    always_comb begin
        logic v_found;
        w_src = i_req;
`ifdef ARB_ROUND_ROBIN_EN
        // Requests strictly above the last grant go first; if none, wrap to the
        // full vector so the lowest index is next in the rotation.
        w_mask = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_mask[i] = (i > int'(i_last));
        end
        w_hi  = i_req & w_mask;
        w_src = (|w_hi) ? w_hi : i_req;
`endif
        v_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        for (int i = 0; i < NPORTS; i++) begin
            o_idx       = (w_src[i] & ~v_found) ? IW'(i) : o_idx;
            o_onehot[i] = w_src[i] & ~v_found;
            v_found     = v_found | w_src[i];
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/arb_n.sv
// ---------------------------------------------------------------------------
// arb_n
// N-master to 1-slave memory arbiter on the core's valid/ready bus.
// Build option: ARB_ROUND_ROBIN_EN selects rotating-priority arbitration;
// without it the lowest-index requester always wins.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   m_valid/m_ready [N]      per-master request / completion pulse
//   m_addr  [N*AW]           packed addresses, port i at [i*AW +: AW]
//   m_wdata [N*DW]           packed write data
//   m_wstrb [N*DW/8]         packed strobes, all zero = read
//   m_rdata [DW]             read data broadcast to all masters
//   mem_*                    downstream memory port
//   fault                    sticky bus-timeout flag (cleared only by rst)
// Every transfer is followed by one IDLE cycle; no back-to-back grant.
// ---------------------------------------------------------------------------
module arb_n
    import arb_n_pkg::*;
#(
    parameter int NPORTS  = 2,
    parameter int AW      = ARB_DEF_AW,
    parameter int DW      = ARB_DEF_DW,
    parameter int TIMEOUT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        m_valid,
    output logic [NPORTS-1:0]        m_ready,
    input  logic [NPORTS*AW-1:0]     m_addr,
    input  logic [NPORTS*DW-1:0]     m_wdata,
    input  logic [NPORTS*DW/8-1:0]   m_wstrb,
    output logic [DW-1:0]            m_rdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic [DW/8-1:0]          mem_wstrb,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     fault
);

    localparam int IW = $clog2(NPORTS);
    localparam int SW = DW / 8;

    arb_state_e         r_state;
    logic [IW-1:0]      r_grant;
    logic [NPORTS-1:0]  r_grant_oh;
    logic               r_fault;

    logic [NPORTS-1:0]  w_pick_oh;
    logic [IW-1:0]      w_pick_idx;
    logic               w_any;
    logic               w_busy;
    logic               w_gvalid;
    logic               w_done;
    logic               w_abort;
    logic               w_tmo_hit;

    assign w_busy   = (r_state == ARB_BUSY);
    assign w_gvalid = |(m_valid & r_grant_oh);
    assign w_done   = w_busy & w_gvalid & mem_ready;
    // Granted master dropped its request: silent abort, no pulse, no fault.
    assign w_abort  = w_busy & ~w_gvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] r_last;

    // Remember the last port that completed normally, seeding the rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IW'(NPORTS - 1);
        end else if (w_done) begin
            r_last <= r_grant;
        end else begin
            r_last <= r_last;
        end
    end
`endif

    arb_n_pick #(
        .NPORTS (NPORTS),
        .IW     (IW)
    ) u_pick (
        .i_req    (m_valid),
`ifdef ARB_ROUND_ROBIN_EN
        .i_last   (r_last),
`endif
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int TW = arb_cnt_w(TIMEOUT);
            logic [TW-1:0] r_tcnt;

            // Count BUSY cycles without mem_ready; held at zero in IDLE so every
            // transfer starts from zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tcnt <= '0;
                end else if (r_state == ARB_IDLE) begin
                    r_tcnt <= '0;
                end else if (!mem_ready) begin
                    r_tcnt <= r_tcnt + TW'(1);
                end else begin
                    r_tcnt <= r_tcnt;
                end
            end

            // mem_ready in the firing cycle wins, hence the ~mem_ready term.
            assign w_tmo_hit = w_busy & w_gvalid & ~mem_ready &
                               (r_tcnt == TW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    // Arbiter FSM: grant capture, completion/abort/timeout return, sticky fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_grant_oh <= NPORTS'(1);
            r_fault    <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_state    <= ARB_BUSY;
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                    end else begin
                        r_state    <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (w_done || w_abort || w_tmo_hit) begin
                        r_state <= ARB_IDLE;
                    end else begin
                        r_state <= ARB_BUSY;
                    end
                    if (w_tmo_hit) begin
                        r_fault <= 1'b1;
                    end else begin
                        r_fault <= r_fault;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Downstream muxing from the granted port; buses read zero outside BUSY.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        m_ready   = '0;
        if (w_busy) begin
            mem_valid = w_gvalid & ~w_tmo_hit;
            mem_addr  = m_addr[int'(r_grant)*AW +: AW];
            mem_wdata = m_wdata[int'(r_grant)*DW +: DW];
            mem_wstrb = m_wstrb[int'(r_grant)*SW +: SW];
            m_ready   = (w_done | w_tmo_hit) ? r_grant_oh : '0;
        end else begin
            mem_valid = 1'b0;
        end
        // A timed-out transfer completes with zero data.
        m_rdata = w_tmo_hit ? '0 : mem_rdata;
    end

    assign fault = r_fault;

endmodule

// File: tb/tb_arb_n.sv
// ---------------------------------------------------------------------------
// tb_arb_n
// Randomized scoreboard bench for arb_n (NPORTS=4, AW=16, DW=32, TIMEOUT=4).
// The driver picks the expected winner from the pending request set with a
// plain priority rule, chooses a memory latency (latencies above 4 time out,
// latency 4 exercises the mem_ready/timeout race) and queues the expected
// transfer. A separate monitor checks the downstream request and the
// completion pulse against the queue head.
// ---------------------------------------------------------------------------
module tb_arb_n;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;
    localparam int RST_ROUND = 150;

    logic                clk = 1'b0;
    logic                rst;
    logic [NP-1:0]       m_valid;
    logic [NP-1:0]       m_ready;
    logic [NP*AW-1:0]    m_addr;
    logic [NP*DW-1:0]    m_wdata;
    logic [NP*SW-1:0]    m_wstrb;
    logic [DW-1:0]       m_rdata;
    logic                mem_valid;
    logic                mem_ready;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [SW-1:0]       mem_wstrb;
    logic [DW-1:0]       mem_rdata;
    logic                fault;

    arb_n #(.NPORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          tmo;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          passed = 0;
    bit          sticky = 1'b0;
    bit          mon_en = 1'b0;
    bit          prev_mv = 1'b0;
    bit          pend[NP];
    logic [15:0] a[NP];
    logic [31:0] d[NP];
    logic [3:0]  s[NP];
    int          lst;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    // Reference arbitration rule from the pending set and the last served port.
    function automatic int pick_model(input int last_p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NP; k++) begin
            if (pend[(last_p + k) % NP]) return (last_p + k) % NP;
        end
`else
        for (int p = 0; p < NP; p++) begin
            if (pend[p]) return p;
        end
`endif
        return -1;
    endfunction

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        a[i] = 16'($urandom);
        d[i] = $urandom;
        s[i] = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
        m_valid[i] = 1'b1;
        m_addr[i*AW +: AW]  = a[i];
        m_wdata[i*DW +: DW] = d[i];
        m_wstrb[i*SW +: SW] = s[i];
    endtask

    // Monitor: compares DUT outputs against the queue head, away from posedge.
    always @(negedge clk) begin
        #2;
        if (mon_en && !rst) begin
            if (mem_valid && !prev_mv) begin
                if (q.size() == 0) begin
                    check("unexpected_mem_valid", 64'd1, 64'd0);
                end else begin
                    check("mem_addr",  64'(mem_addr),  64'(q[0].addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
                    check("mem_wstrb", 64'(mem_wstrb), 64'(q[0].wstrb));
                end
            end
            if (m_ready != '0) begin
                if (q.size() == 0) begin
                    check("unexpected_m_ready", 64'(m_ready), 64'd0);
                end else begin
                    exp_t e;
                    logic [NP-1:0] oh;
                    e = q.pop_front();
                    oh = '0;
                    oh[e.port] = 1'b1;
                    check("m_ready_port", 64'(m_ready), 64'(oh));
                    check("m_rdata", 64'(m_rdata), e.tmo ? 64'd0 : 64'(e.rdata));
                    check("fault_before", 64'(fault), 64'(sticky));
                    if (e.tmo) begin
                        check("tmo_mem_valid", 64'(mem_valid), 64'd0);
                        sticky = 1'b1;
                    end
                end
            end else begin
                check("rdata_pass", 64'(m_rdata), 64'(mem_rdata));
            end
            if (!mem_valid && m_ready == '0) begin
                check("idle_bus_zero", {mem_addr, mem_wstrb, 12'h0, mem_wdata}, 64'd0);
            end
        end
        prev_mv = mem_valid;
    end

    initial begin
        int   w, lat, n, k;
        bit   tmo, any;
        logic [31:0] rd;
        exp_t e;
        rst = 1'b1;
        m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < NP; i++) pend[i] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_m_ready",   64'(m_ready),   64'd0);
        check("rst_fault",     64'(fault),     64'd0);
        rst = 1'b0;
        lst = NP - 1;
        mon_en = 1'b1;
        for (int r = 0; r < 200; r++) begin
            any = 1'b0;
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && (r == 0 || $urandom_range(0, 2) == 0)) new_req(i);
                any = any | pend[i];
            end
            if (!any) new_req(int'($urandom_range(0, NP - 1)));
            w = pick_model(lst);
            lat = (r == 3) ? TO : (r == 5) ? TO + 1 : int'($urandom_range(1, 6));
            tmo = (lat > TO);
            rd = $urandom;
            e.port = w; e.addr = a[w]; e.wdata = d[w]; e.wstrb = s[w];
            e.rdata = rd; e.tmo = tmo;
            q.push_back(e);
            mem_rdata = $urandom;
            @(negedge clk);
            k = 0;
            while (!mem_valid && k < 4) begin
                @(negedge clk);
                k++;
            end
            if (!mem_valid) begin
                check("grant_wait", 64'd0, 64'd1);
                break;
            end
            if (r == RST_ROUND) begin
                #3 rst = 1'b1;
                #1;
                check("arst_mem_valid", 64'(mem_valid), 64'd0);
                check("arst_m_ready",   64'(m_ready),   64'd0);
                check("arst_fault",     64'(fault),     64'd0);
                q.delete();
                sticky = 1'b0;
                lst = NP - 1;
                @(negedge clk);
                rst = 1'b0;
                continue;
            end
            n = tmo ? TO : lat;
            for (int c = 1; c <= n; c++) begin
                mem_ready = (c == lat);
                mem_rdata = (c == lat) ? rd : $urandom;
                if (c < n) @(negedge clk);
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            pend[w] = 1'b0;
            m_valid[w] = 1'b0;
            if (!tmo) lst = w;
        end
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("fault_final", 64'(fault), 64'(sticky));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
